alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station feeding the combinational ALU execute stage.
- Accepts dispatched ALU/branch/jump ops from the decoder, holding up to RS_SIZE entries.
- Snoops the ALU and LSB result broadcasts to wake up pending operands.
- Issues at most one ready op per cycle into a registered issue port that drives the ALU (opnum, V1, V2, imm, pc, rob_id).

Parameters:
- RS_SIZE, 16, number of entries (power of 2, ≥4)
- RS_IDX_W, 4, log2(RS_SIZE)
- OPNUM_W, 6, opcode-number width; value 0 is OPNUM_NULL
- ROB_ID_W, 4, ROB tag width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low freezes all state
- rollback  in  1  mispredict flush
- dispatch_valid  in  1  new op this cycle
- dispatch_opnum  in  OPNUM_W  op number
- dispatch_V1, dispatch_V2  in  32  operand values, valid when the matching ready bit is 1
- dispatch_Q1, dispatch_Q2  in  ROB_ID_W  producer ROB tags, valid when the matching ready bit is 0
- dispatch_ready1, dispatch_ready2  in  1  operand already available
- dispatch_imm  in  32  immediate
- dispatch_pc  in  32  instruction pc
- dispatch_rob_id  in  ROB_ID_W  destination tag
- alu_cdb_valid  in  1  ALU broadcast valid
- alu_cdb_rob_id  in  ROB_ID_W  ALU broadcast tag
- alu_cdb_data  in  32  ALU broadcast data
- lsb_cdb_valid  in  1  LSB broadcast valid
- lsb_cdb_rob_id  in  ROB_ID_W  LSB broadcast tag
- lsb_cdb_data  in  32  LSB broadcast data
- full  out  1  dispatcher must not send next cycle
- opnum_to_ex  out  OPNUM_W  issued op; OPNUM_NULL = nothing issued
- V1_to_ex, V2_to_ex, imm_to_ex, pc_to_ex  out  32  issued fields
- rob_id_to_ex  out  ROB_ID_W  issued tag

Behaviour:
- Reset (rst_n low, async):
  - All entries not busy.
  - opnum_to_ex=OPNUM_NULL; all other *_to_ex outputs = 0; full=0.
- rdy low: no register changes, including issue outputs (downstream is frozen too).
- rollback (rdy high), at the edge:
  - All entries cleared; opnum_to_ex=OPNUM_NULL.
  - Overrides dispatch, issue and wakeup in the same cycle.
- Dispatch:
  - When dispatch_valid is high, the op is written into the lowest-index free entry.
  - Dispatch with no free entry is a protocol violation: the op is dropped and no state is corrupted.
- Dispatch bypass: if an incoming operand has ready=0 and a valid broadcast this cycle carries a tag equal to its Q, the entry is stored with V = broadcast data and ready=1.
- Wakeup, every cycle, for each busy entry:
  - Any operand with ready=0 whose Q matches a valid alu_cdb or lsb_cdb tag captures that data and sets ready=1.
  - Both sources are checked in parallel; if both match the same tag, ALU data wins.
- Select:
  - Candidate = busy entry with ready1 and ready2 both set, evaluated on registered state only.
  - An entry dispatched this cycle is not eligible until the next cycle.
  - An operand woken this cycle becomes eligible next cycle.
  - Winner = lowest index.
- Issue:
  - The winner's fields are registered into *_to_ex and the entry is freed at the same edge.
  - With no candidate, opnum_to_ex=OPNUM_NULL and other outputs hold their previous values.
- Latency: minimum dispatch-to-issue-output is 2 edges (write, then select/issue).
- full: registered; asserted when the busy count after this edge is ≥ RS_SIZE-1. This gives one slot of slack for a dispatch already in flight.
- A free slot may be reused on the same edge an entry is issued, but a dispatch never targets the entry being freed that cycle.

Optional Feature:
- Macro: RS_AGE_SELECT_EN.
- Defined:
  - Each entry carries a 4-bit age, cleared on dispatch and incremented (saturating at 15) every rdy cycle while busy.
  - Select picks the ready entry with the largest age; ties go to the lowest index.
- Undefined: pure lowest-index select, and no age storage.

Test Plan:
- Reset low mid-operation with 3 busy entries → on release, opnum_to_ex=0, full=0, next issue only after a new dispatch.
- Dispatch ADD (both ready: V1=5, V2=7, rob_id=3) at cycle 0 → cycle 2 shows opnum_to_ex=ADD, V1_to_ex=5, V2_to_ex=7, rob_id_to_ex=3, then NULL.
- Dispatch SUB with Q1=6 not ready, then alu_cdb_valid with rob_id=6, data=0x100 one cycle later → next issue shows V1_to_ex=0x100. The same case with the broadcast in the dispatch cycle (bypass) issues one cycle earlier.
- Fill 15 entries with unready ops → full=1. Broadcast one tag releasing entry 2 → issue of entry 2 and full drops the following cycle.
- rollback while 5 entries are busy and the same-cycle dispatch_valid is high → all cleared, nothing issued for 3 subsequent cycles.
- RS_AGE_SELECT_EN: entry 4 dispatched before entry 1 and both become ready together → entry 4 issues first. Without the macro, entry 1 issues first.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station for the ALU execute stage with CDB wakeup and one registered issue per cycle.
// Optional RS_AGE_SELECT_EN: oldest-ready select instead of lowest-index select.
module alu_rs #(
    parameter int RS_SIZE  = 16,
    parameter int RS_IDX_W = 4,
    parameter int OPNUM_W  = 6,
    parameter int ROB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                dispatch_valid,
    input  logic [OPNUM_W-1:0]  dispatch_opnum,
    input  logic [31:0]         dispatch_V1,
    input  logic [31:0]         dispatch_V2,
    input  logic [ROB_ID_W-1:0] dispatch_Q1,
    input  logic [ROB_ID_W-1:0] dispatch_Q2,
    input  logic                dispatch_ready1,
    input  logic                dispatch_ready2,
    input  logic [31:0]         dispatch_imm,
    input  logic [31:0]         dispatch_pc,
    input  logic [ROB_ID_W-1:0] dispatch_rob_id,
    input  logic                alu_cdb_valid,
    input  logic [ROB_ID_W-1:0] alu_cdb_rob_id,
    input  logic [31:0]         alu_cdb_data,
    input  logic                lsb_cdb_valid,
    input  logic [ROB_ID_W-1:0] lsb_cdb_rob_id,
    input  logic [31:0]         lsb_cdb_data,
    output logic                full,
    output logic [OPNUM_W-1:0]  opnum_to_ex,
    output logic [31:0]         V1_to_ex,
    output logic [31:0]         V2_to_ex,
    output logic [31:0]         imm_to_ex,
    output logic [31:0]         pc_to_ex,
    output logic [ROB_ID_W-1:0] rob_id_to_ex
);
    localparam logic [OPNUM_W-1:0]  OPNUM_NULL = '0;
    localparam logic [RS_IDX_W:0]   FULL_AT    = (RS_IDX_W + 1)'(RS_SIZE - 1);

    logic [RS_SIZE-1:0]  busy, r1, r2, cand, busy_nxt;
    logic [OPNUM_W-1:0]  opnum [RS_SIZE];
    logic [31:0]         v1 [RS_SIZE];
    logic [31:0]         v2 [RS_SIZE];
    logic [31:0]         imm [RS_SIZE];
    logic [31:0]         pc [RS_SIZE];
    logic [ROB_ID_W-1:0] q1 [RS_SIZE];
    logic [ROB_ID_W-1:0] q2 [RS_SIZE];
    logic [ROB_ID_W-1:0] rob [RS_SIZE];
`ifdef RS_AGE_SELECT_EN
    logic [3:0]          age [RS_SIZE];
    logic [3:0]          sel_age;
`endif
    logic                sel_found, free_found, do_disp;
    logic [RS_IDX_W-1:0] sel_idx, free_idx;
    logic [RS_IDX_W:0]   cnt_nxt;

    // ALU beats LSB when both broadcast the awaited tag
    function automatic logic [32:0] snoop(input logic r, input logic [31:0] v, input logic [ROB_ID_W-1:0] q);
        return r ? {1'b1, v} :
               (alu_cdb_valid && alu_cdb_rob_id == q) ? {1'b1, alu_cdb_data} :
               (lsb_cdb_valid && lsb_cdb_rob_id == q) ? {1'b1, lsb_cdb_data} : {1'b0, v};
    endfunction

    assign cand = busy & r1 & r2;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef RS_AGE_SELECT_EN
        sel_age   = '0;
        for (int i = 0; i < RS_SIZE; i++)
            if (cand[i] && (!sel_found || age[i] > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = RS_IDX_W'(i);
                sel_age   = age[i];
            end
`else
        for (int i = 0; i < RS_SIZE; i++)
            if (cand[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = RS_IDX_W'(i);
            end
`endif
    end

    // free slots come from registered busy, so the entry issuing this cycle is never targeted
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++)
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = RS_IDX_W'(i);
            end
    end

    assign do_disp = dispatch_valid && free_found;

    always_comb begin
        busy_nxt = busy;
        if (sel_found)
            busy_nxt[sel_idx] = 1'b0;
        if (do_disp)
            busy_nxt[free_idx] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < RS_SIZE; i++)
            cnt_nxt = cnt_nxt + (RS_IDX_W + 1)'(busy_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            full         <= 1'b0;
            opnum_to_ex  <= OPNUM_NULL;
            V1_to_ex     <= '0;
            V2_to_ex     <= '0;
            imm_to_ex    <= '0;
            pc_to_ex     <= '0;
            rob_id_to_ex <= '0;
        end else if (rdy) begin
            if (rollback) begin
                busy        <= '0;
                full        <= 1'b0;
                opnum_to_ex <= OPNUM_NULL;
            end else begin
                busy        <= busy_nxt;
                full        <= cnt_nxt >= FULL_AT;
                opnum_to_ex <= sel_found ? opnum[sel_idx] : OPNUM_NULL;
                if (sel_found) begin
                    V1_to_ex     <= v1[sel_idx];
                    V2_to_ex     <= v2[sel_idx];
                    imm_to_ex    <= imm[sel_idx];
                    pc_to_ex     <= pc[sel_idx];
                    rob_id_to_ex <= rob[sel_idx];
                end
            end
        end
    end

    // payload is only meaningful while busy, so it needs no reset
    always_ff @(posedge clk) begin
        if (rdy && !rollback) begin
            for (int i = 0; i < RS_SIZE; i++)
                if (busy[i]) begin
                    {r1[i], v1[i]} <= snoop(r1[i], v1[i], q1[i]);
                    {r2[i], v2[i]} <= snoop(r2[i], v2[i], q2[i]);
`ifdef RS_AGE_SELECT_EN
                    age[i] <= age[i] + 4'(age[i] != 4'hF);
`endif
                end
            if (do_disp) begin
                {r1[free_idx], v1[free_idx]} <= snoop(dispatch_ready1, dispatch_V1, dispatch_Q1);
                {r2[free_idx], v2[free_idx]} <= snoop(dispatch_ready2, dispatch_V2, dispatch_Q2);
                opnum[free_idx] <= dispatch_opnum;
                q1[free_idx]    <= dispatch_Q1;
                q2[free_idx]    <= dispatch_Q2;
                imm[free_idx]   <= dispatch_imm;
                pc[free_idx]    <= dispatch_pc;
                rob[free_idx]   <= dispatch_rob_id;
`ifdef RS_AGE_SELECT_EN
                age[free_idx]   <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: table-driven and sequence checks for alu_rs with an issue scoreboard.
module tb_alu_rs;
    logic        clk = 1'b0, rst_n, rdy, rollback;
    logic        dispatch_valid, dispatch_ready1, dispatch_ready2;
    logic [5:0]  dispatch_opnum;
    logic [31:0] dispatch_V1, dispatch_V2, dispatch_imm, dispatch_pc;
    logic [3:0]  dispatch_Q1, dispatch_Q2, dispatch_rob_id;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [3:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
    logic [31:0] alu_cdb_data, lsb_cdb_data;
    logic        full;
    logic [5:0]  opnum_to_ex;
    logic [31:0] V1_to_ex, V2_to_ex, imm_to_ex, pc_to_ex;
    logic [3:0]  rob_id_to_ex;

    alu_rs dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
        .dispatch_valid(dispatch_valid), .dispatch_opnum(dispatch_opnum),
        .dispatch_V1(dispatch_V1), .dispatch_V2(dispatch_V2),
        .dispatch_Q1(dispatch_Q1), .dispatch_Q2(dispatch_Q2),
        .dispatch_ready1(dispatch_ready1), .dispatch_ready2(dispatch_ready2),
        .dispatch_imm(dispatch_imm), .dispatch_pc(dispatch_pc), .dispatch_rob_id(dispatch_rob_id),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_data(alu_cdb_data),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_data(lsb_cdb_data),
        .full(full), .opnum_to_ex(opnum_to_ex), .V1_to_ex(V1_to_ex), .V2_to_ex(V2_to_ex),
        .imm_to_ex(imm_to_ex), .pc_to_ex(pc_to_ex), .rob_id_to_ex(rob_id_to_ex)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    logic [137:0] sbq[$];
    logic [137:0] sb_e;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] v1, v2;
        logic [3:0]  q1, q2;
        logic        r1, r2;
        logic [31:0] imm, pc;
        logic [3:0]  rob;
        int          at;
        logic        av;
        logic [3:0]  atag;
        logic [31:0] ad;
        logic        lv;
        logic [3:0]  ltag;
        logic [31:0] ld;
        logic [31:0] ev1, ev2;
        int          lat;
    } vec_t;
    vec_t vt[9];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = 0; rollback = 0; alu_cdb_valid = 0; lsb_cdb_valid = 0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [3:0] q1, input logic [3:0] q2, input logic r1, input logic r2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        dispatch_valid = 1; dispatch_opnum = op; dispatch_V1 = v1; dispatch_V2 = v2;
        dispatch_Q1 = q1; dispatch_Q2 = q2; dispatch_ready1 = r1; dispatch_ready2 = r2;
        dispatch_imm = imm; dispatch_pc = pc; dispatch_rob_id = rob;
    endtask

    task automatic alu_bc(input logic [3:0] tag, input logic [31:0] d);
        alu_cdb_valid = 1; alu_cdb_rob_id = tag; alu_cdb_data = d;
    endtask

    always @(negedge clk)
        if (rst_n && rdy && opnum_to_ex != 0) begin
            if (sbq.size() == 0) check("unexpected_issue", opnum_to_ex, 0);
            else begin
                sb_e = sbq.pop_front();
                check("sb_issue", {opnum_to_ex, V1_to_ex, V2_to_ex, imm_to_ex, pc_to_ex, rob_id_to_ex}, sb_e);
            end
        end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [3:0] first_rob, second_rob;
        vt[0] = '{6'd1, 32'd5, 32'd7, 4'd0, 4'd0, 1'b1, 1'b1, 32'h0, 32'h1000, 4'd3, 0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'd5, 32'd7, 2};
        vt[1] = '{6'd2, 32'd0, 32'd2, 4'd6, 4'd0, 1'b0, 1'b1, 32'h0, 32'h1004, 4'd4, 1, 1'b1, 4'd6, 32'h100, 1'b0, 4'd0, 32'h0, 32'h100, 32'd2, 3};
        vt[2] = '{6'd2, 32'd0, 32'd2, 4'd6, 4'd0, 1'b0, 1'b1, 32'h0, 32'h1008, 4'd5, 0, 1'b1, 4'd6, 32'h100, 1'b0, 4'd0, 32'h0, 32'h100, 32'd2, 2};
        vt[3] = '{6'd3, 32'd9, 32'd0, 4'd0, 4'd9, 1'b1, 1'b0, 32'h44, 32'h100c, 4'd6, 1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 32'hdead, 32'd9, 32'hdead, 3};
        vt[4] = '{6'd4, 32'd0, 32'd0, 4'd5, 4'd5, 1'b0, 1'b0, 32'h8, 32'h1010, 4'd7, 0, 1'b1, 4'd5, 32'hab, 1'b0, 4'd0, 32'h0, 32'hab, 32'hab, 2};
        vt[5] = '{6'd5, 32'd0, 32'd3, 4'd6, 4'd0, 1'b0, 1'b1, 32'h0, 32'h1014, 4'd8, 1, 1'b1, 4'd6, 32'h111, 1'b1, 4'd6, 32'h222, 32'h111, 32'd3, 3};
        vt[6] = '{6'd6, 32'd0, 32'd0, 4'd7, 4'd8, 1'b0, 1'b0, 32'h1, 32'h1018, 4'd9, 1, 1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88, 32'h77, 32'h88, 3};
        vt[7] = '{6'd7, 32'd1, 32'd0, 4'd0, 4'd12, 1'b1, 1'b0, 32'h0, 32'h101c, 4'd10, 0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd12, 32'hc0ffee, 32'd1, 32'hc0ffee, 2};
        vt[8] = '{6'd8, 32'h55, 32'd1, 4'd3, 4'd4, 1'b1, 1'b0, 32'h0, 32'h1020, 4'd11, 0, 1'b1, 4'd3, 32'h999, 1'b1, 4'd4, 32'h44, 32'h55, 32'h44, 2};

        rst_n = 0; rdy = 1; idle();
        disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); dispatch_valid = 0;
        alu_cdb_rob_id = 0; alu_cdb_data = 0; lsb_cdb_rob_id = 0; lsb_cdb_data = 0;
        step(); step();
        rst_n = 1;
        step();
        check("rst_opnum", opnum_to_ex, 0);
        check("rst_v1", V1_to_ex, 0);
        check("rst_v2", V2_to_ex, 0);
        check("rst_imm", imm_to_ex, 0);
        check("rst_pc", pc_to_ex, 0);
        check("rst_rob", rob_id_to_ex, 0);
        check("rst_full", full, 0);

        for (int k = 0; k < 9; k++) begin
            disp(vt[k].op, vt[k].v1, vt[k].v2, vt[k].q1, vt[k].q2, vt[k].r1, vt[k].r2, vt[k].imm, vt[k].pc, vt[k].rob);
            alu_cdb_valid = (vt[k].at == 0) && vt[k].av; alu_cdb_rob_id = vt[k].atag; alu_cdb_data = vt[k].ad;
            lsb_cdb_valid = (vt[k].at == 0) && vt[k].lv; lsb_cdb_rob_id = vt[k].ltag; lsb_cdb_data = vt[k].ld;
            sbq.push_back({vt[k].op, vt[k].ev1, vt[k].ev2, vt[k].imm, vt[k].pc, vt[k].rob});
            lat = 0;
            for (int c = 1; c <= 6 && lat == 0; c++) begin
                step();
                idle();
                if (c == 1 && vt[k].at == 1) begin
                    alu_cdb_valid = vt[k].av; lsb_cdb_valid = vt[k].lv;
                end
                if (opnum_to_ex != 0) lat = c;
            end
            check($sformatf("latency_%0d", k), lat, vt[k].lat);
            idle();
            step();
            check($sformatf("null_after_%0d", k), opnum_to_ex, 0);
        end

        // held in RS while rdy is low
        disp(6'd12, 32'd1, 32'd2, 0, 0, 1, 1, 32'd3, 32'h4000, 4'd1);
        sbq.push_back({6'd12, 32'd1, 32'd2, 32'd3, 32'h4000, 4'd1});
        step(); idle();
        rdy = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("rdy_low_hold", opnum_to_ex, 0);
        end
        rdy = 1;
        step();
        check("rdy_release_issue", opnum_to_ex, 12);
        step();

        // fill to the full threshold, then release entry 2
        for (int i = 0; i < 15; i++) begin
            disp(6'd9, 32'd0, 32'(i), 4'(i), 0, 0, 1, 0, 32'(i * 4), 4'(i));
            step(); idle();
            if (i == 13) check("full_at_14", full, 0);
        end
        check("full_at_15", full, 1);
        alu_bc(4'd2, 32'h222);
        sbq.push_back({6'd9, 32'h222, 32'd2, 32'd0, 32'd8, 4'd2});
        step(); idle();
        check("full_wake_cycle", full, 1);
        check("no_issue_wake_cycle", opnum_to_ex, 0);
        step();
        check("issue_entry2_rob", rob_id_to_ex, 2);
        check("full_drops", full, 0);
        rollback = 1;
        step(); idle();
        check("rollback_full", full, 0);

        // rollback overrides a same-cycle dispatch and broadcast
        for (int i = 1; i <= 5; i++) begin
            disp(6'd13, 0, 0, 4'(i), 0, 0, 1, 0, 0, 4'(i));
            step(); idle();
        end
        rollback = 1;
        disp(6'd14, 1, 1, 0, 0, 1, 1, 0, 0, 4'd15);
        alu_bc(4'd1, 32'h1);
        step(); idle();
        for (int c = 0; c < 3; c++) begin
            alu_bc(4'(c + 2), 32'h5);
            lsb_cdb_valid = 1; lsb_cdb_rob_id = 4'(c % 2 == 0 ? 1 : 5); lsb_cdb_data = 32'h6;
            step(); idle();
            check("rollback_no_issue", opnum_to_ex, 0);
        end
        check("rollback_not_full", full, 0);

        // async reset mid-operation
        for (int i = 0; i < 3; i++) begin
            disp(6'd15, 0, 0, 4'(10 + i), 0, 0, 1, 0, 0, 4'(i));
            step(); idle();
        end
        #2 rst_n = 0;
        #1 check("async_rst_opnum", opnum_to_ex, 0);
        step();
        #2 rst_n = 1;
        step();
        check("post_rst_full", full, 0);
        for (int c = 0; c < 3; c++) begin
            alu_bc(4'(10 + c), 32'h7);
            step(); idle();
            check("post_rst_no_issue", opnum_to_ex, 0);
        end
        disp(6'd16, 32'd8, 32'd9, 0, 0, 1, 1, 0, 32'h5000, 4'd6);
        sbq.push_back({6'd16, 32'd8, 32'd9, 32'd0, 32'h5000, 4'd6});
        step(); idle(); step();
        check("post_rst_new_issue", opnum_to_ex, 16);
        step();

        // entry 4 older than entry 1, both woken together
        for (int i = 0; i < 5; i++) begin
            disp(6'(10 + i), 0, 32'(32'h20 + i), (i == 4) ? 4'd9 : 4'(i), 0, 0, 1, 0, 32'(32'h2000 + 4 * i), 4'(i));
            step(); idle();
        end
        alu_bc(4'd1, 32'h10);
        sbq.push_back({6'd11, 32'h10, 32'h21, 32'd0, 32'h2004, 4'd1});
        step(); idle(); step();
        check("age_pre_issue", rob_id_to_ex, 1);
        disp(6'd20, 0, 32'h30, 4'd9, 0, 0, 1, 0, 32'h3000, 4'd11);
        step(); idle();
`ifdef RS_AGE_SELECT_EN
        first_rob = 4'd4; second_rob = 4'd11;
        sbq.push_back({6'd14, 32'h99, 32'h24, 32'd0, 32'h2010, 4'd4});
        sbq.push_back({6'd20, 32'h99, 32'h30, 32'd0, 32'h3000, 4'd11});
`else
        first_rob = 4'd11; second_rob = 4'd4;
        sbq.push_back({6'd20, 32'h99, 32'h30, 32'd0, 32'h3000, 4'd11});
        sbq.push_back({6'd14, 32'h99, 32'h24, 32'd0, 32'h2010, 4'd4});
`endif
        alu_bc(4'd9, 32'h99);
        step(); idle(); step();
        check("select_first", rob_id_to_ex, first_rob);
        step();
        check("select_second", rob_id_to_ex, second_rob);
        rollback = 1;
        step(); idle(); step();

        check("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
